// File: rtl/act_unit_arbiter.sv
// act_unit_arbiter: round-robin share of one fixed-point sigmoid datapath among N_REQ requesters.
// Latency: an accept in cycle k presents its result in cycle k+1; one result per cycle while out_ready.
// Backpressure: while out_valid && !out_ready the result is held and no grant is issued.
// Optional tanh derivation from the same sigmoid unit: define ACT_UNIT_ARBITER_TANH_EN.

// Piecewise-linear sigmoid, purely combinational. Output lies in [0, 1.0] in the same Q format.
// Segments (on |x|): <1: x/4+0.5, <2.375: x/8+0.625, <5: x/32+0.84375, else 1.0;
// negative inputs use sigmoid(-x) = 1 - sigmoid(x). The reset input forces the output to zero.
module sigmoid #(
   parameter int INT_WIDTH  = 8,
   parameter int FRAC_WIDTH = 8,
   localparam int W = INT_WIDTH + FRAC_WIDTH + 1
) (
   input  logic                reset,
   input  logic signed [W-1:0] x_i,
   output logic signed [W-1:0] y_o
);

   localparam logic [W-1:0] ONE   = W'(1)  << FRAC_WIDTH;
   localparam logic [W-1:0] HALF  = W'(1)  << (FRAC_WIDTH - 1);
   localparam logic [W-1:0] T_MID = W'(19) << (FRAC_WIDTH - 3);   // 2.375
   localparam logic [W-1:0] T_SAT = W'(5)  << FRAC_WIDTH;         // 5.0
   localparam logic [W-1:0] C_LOW = W'(5)  << (FRAC_WIDTH - 3);   // 0.625
   localparam logic [W-1:0] C_MID = W'(27) << (FRAC_WIDTH - 5);   // 0.84375

   logic         neg;
   logic [W-1:0] mag;
   logic [W-1:0] pos;
   logic [W-1:0] pos_c;
   logic [W-1:0] y_u;

   // Evaluate the positive half on |x| and mirror it for negative operands.
   always_comb begin
      neg = x_i[W-1];
      // Magnitude of the most negative value still fits as an unsigned W-bit number.
      mag = neg ? (~x_i + W'(1)) : x_i;
      if (mag >= T_SAT) begin
         pos = ONE;
      end else if (mag >= T_MID) begin
         pos = (mag >> 5) + C_MID;
      end else if (mag >= ONE) begin
         pos = (mag >> 3) + C_LOW;
      end else begin
         pos = (mag >> 2) + HALF;
      end
      pos_c = (pos > ONE) ? ONE : pos;
      y_u   = neg ? (ONE - pos_c) : pos_c;
      y_o   = reset ? '0 : $signed(y_u);
   end

endmodule

module act_unit_arbiter #(
   parameter int INT_WIDTH  = 8,
   parameter int FRAC_WIDTH = 8,
   parameter int WIDTH      = INT_WIDTH + FRAC_WIDTH + 1,
   parameter int N_REQ      = 3,
   parameter int TAG_W      = $clog2(N_REQ)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [N_REQ-1:0]         req_valid,
   output logic [N_REQ-1:0]         req_ready,
   input  logic [N_REQ*WIDTH-1:0]   req_data,
   input  logic [N_REQ-1:0]         req_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [WIDTH-1:0]  out_data,
   output logic [TAG_W-1:0]         out_tag,
   output logic                     out_op
);

   // Round-robin pointer: index of the most recently granted requester.
   logic [TAG_W-1:0]        ptr_q, ptr_d;
   logic                    out_valid_q, out_valid_d;
   logic signed [WIDTH-1:0] out_data_q, out_data_d;
   logic [TAG_W-1:0]        out_tag_q, out_tag_d;
   logic                    out_op_q, out_op_d;

   logic                    can_issue;
   logic                    found;
   logic                    accept;
   logic [TAG_W-1:0]        gidx;
   logic signed [WIDTH-1:0] sel_data;
   logic signed [WIDTH-1:0] sig_in;
   logic signed [WIDTH-1:0] sig_out;
   logic signed [WIDTH-1:0] res;
   logic                    res_op;

   assign can_issue = !out_valid_q || out_ready;
   assign accept    = found && can_issue && !reset;

   // Round-robin search: first valid above the pointer, otherwise first valid from index 0.
   always_comb begin
      found = 1'b0;
      gidx  = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (!found && req_valid[j] && (j > int'(ptr_q))) begin
            found = 1'b1;
            gidx  = TAG_W'(j);
         end
      end
      for (int j = 0; j < N_REQ; j++) begin
         if (!found && req_valid[j]) begin
            found = 1'b1;
            gidx  = TAG_W'(j);
         end
      end
   end

   // One-hot grant, suppressed while the output register cannot take a new result or in reset.
   always_comb begin
      req_ready = '0;
      for (int j = 0; j < N_REQ; j++) begin
         req_ready[j] = accept && (int'(gidx) == j);
      end
   end

   // Steer the granted lane's operand into the shared datapath; other lanes are ignored.
   always_comb begin
      sel_data = '0;
      for (int j = 0; j < N_REQ; j++) begin
         if (int'(gidx) == j) begin
            sel_data = req_data[j*WIDTH +: WIDTH];
         end
      end
   end

`ifdef ACT_UNIT_ARBITER_TANH_EN
   localparam logic signed [WIDTH-1:0] MAX_V  = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH-1:0] MIN_V  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic signed [WIDTH:0]   ONE_X  = {{(INT_WIDTH+1){1'b0}}, 1'b1, {FRAC_WIDTH{1'b0}}};
   localparam logic signed [WIDTH:0]   NONE_X = -ONE_X;

   logic                    sel_op;
   logic signed [WIDTH:0]   two_x;
   logic signed [WIDTH-1:0] xs;
   logic signed [WIDTH:0]   s_ext;
   logic signed [WIDTH:0]   t_raw;
   logic signed [WIDTH:0]   t_sat;

   // Pick the granted lane's op bit.
   always_comb begin
      sel_op = 1'b0;
      for (int j = 0; j < N_REQ; j++) begin
         if (int'(gidx) == j) begin
            sel_op = req_op[j];
         end
      end
   end

   // tanh(x) = 2*sigmoid(2x) - 1: double with saturation before the sigmoid, rescale after.
   always_comb begin
      two_x = {sel_data, 1'b0};
      if (two_x[WIDTH] != two_x[WIDTH-1]) begin
         xs = two_x[WIDTH] ? MIN_V : MAX_V;
      end else begin
         xs = two_x[WIDTH-1:0];
      end
      sig_in = sel_op ? xs : sel_data;
      s_ext  = {sig_out[WIDTH-1], sig_out};
      t_raw  = (s_ext <<< 1) - ONE_X;
      if (t_raw > ONE_X) begin
         t_sat = ONE_X;
      end else if (t_raw < NONE_X) begin
         t_sat = NONE_X;
      end else begin
         t_sat = t_raw;
      end
      res    = sel_op ? t_sat[WIDTH-1:0] : sig_out;
      res_op = sel_op;
   end
`else
   // Op bits carry no meaning in a sigmoid-only build.
   logic unused_req_op;
   assign unused_req_op = ^req_op;

   // Every request goes straight through the sigmoid.
   always_comb begin
      sig_in = sel_data;
      res    = sig_out;
      res_op = 1'b0;
   end
`endif

   sigmoid #(
      .INT_WIDTH  (INT_WIDTH),
      .FRAC_WIDTH (FRAC_WIDTH)
   ) u_sigmoid (
      .reset (1'b0),
      .x_i   (sig_in),
      .y_o   (sig_out)
   );

   // Next state: load on accept, drop valid when drained without a new accept, else hold.
   always_comb begin
      ptr_d       = ptr_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_tag_d   = out_tag_q;
      out_op_d    = out_op_q;
      if (accept) begin
         ptr_d       = gidx;
         out_valid_d = 1'b1;
         out_data_d  = res;
         out_tag_d   = gidx;
         out_op_d    = res_op;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   // State registers; reset discards any held result and gives requester 0 first priority.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q       <= TAG_W'(N_REQ - 1);
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_tag_q   <= '0;
         out_op_q    <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_tag_q   <= out_tag_d;
         out_op_q    <= out_op_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_tag   = out_tag_q;
   assign out_op    = out_op_q;

endmodule

// File: tb/tb_act_unit_arbiter.sv
// tb_act_unit_arbiter: directed stimulus with a result scoreboard for act_unit_arbiter.
// Expected results are queued on each accept and compared when out_valid && out_ready.
// Defaults: INT_WIDTH=8, FRAC_WIDTH=8 (WIDTH=17), N_REQ=3.
module tb_act_unit_arbiter;

   localparam int W = 17;
   localparam int N = 3;

   typedef struct packed {
      logic [1:0]   tag;
      logic [W-1:0] data;
      logic         op;
   } exp_t;

   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_data;
   logic [N-1:0]   req_op;
   logic           out_valid;
   logic           out_ready;
   logic [W-1:0]   out_data;
   logic [1:0]     out_tag;
   logic           out_op;

   logic [W-1:0]   lane_exp [N];
   logic           lane_op  [N];
   exp_t           sb [$];
   exp_t           e;

   int n_vec = 0;
   int n_err = 0;

   act_unit_arbiter dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_op    (req_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_tag   (out_tag),
      .out_op    (out_op)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input int d, input logic op, input int ex, input logic exop);
      req_data[i*W +: W] = W'(d);
      req_op[i]          = op;
      lane_exp[i]        = W'(ex);
      lane_op[i]         = exop;
   endtask

   // Scoreboard: pop and compare on every output handshake, push on every accept.
   always @(negedge clk) begin
      if (reset) begin
         sb.delete();
      end else begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 32'd1, 32'd0);
            end else begin
               e = sb.pop_front();
               chk("out_tag",  32'(out_tag),  32'(e.tag));
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("out_op",   32'(out_op),   32'(e.op));
            end
         end
         for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb.push_back({2'(i), lane_exp[i], lane_op[i]});
            end
         end
      end
   end

   initial begin
      reset     = 1'b1;
      req_valid = '0;
      req_data  = '0;
      req_op    = '0;
      out_ready = 1'b1;
      set_lane(0, 0, 1'b0, 128, 1'b0);
      set_lane(1, 256, 1'b0, 192, 1'b0);
      set_lane(2, -2048, 1'b0, 0, 1'b0);
      req_valid = 3'b111;

      // Reset state and no grant during reset.
      @(negedge clk);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_data",  32'(out_data),  32'd0);
      chk("rst_tag",   32'(out_tag),   32'd0);
      chk("rst_op",    32'(out_op),    32'd0);

      // Grants 0,1,2 in consecutive cycles.
      step(); reset = 1'b0;
      @(negedge clk); chk("rr_g0", 32'(req_ready), 32'b001);
      step(); req_valid = 3'b110;
      @(negedge clk); chk("rr_g1", 32'(req_ready), 32'b010);
      step(); req_valid = 3'b100;
      @(negedge clk); chk("rr_g2", 32'(req_ready), 32'b100);
      step(); req_valid = 3'b000;
      @(negedge clk); chk("rr_idle", 32'(req_ready), 32'd0);

      // Fairness with requesters 0 and 2 continuously valid.
      step(); req_valid = 3'b101;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("fair_g", 32'(req_ready), (k % 2 == 0) ? 32'b001 : 32'b100);
         step();
      end
      req_valid = 3'b111;
      @(negedge clk); chk("fair_g0b", 32'(req_ready), 32'b001);
      step();
      @(negedge clk); chk("fair_g1", 32'(req_ready), 32'b010);
      step(); req_valid = 3'b000;
      @(negedge clk);

      // Backpressure: hold the result and block grants while out_ready is low.
      step();
      set_lane(0, 0, 1'b0, 128, 1'b0);
      set_lane(1, 256, 1'b0, 192, 1'b0);
      req_valid = 3'b011;
      @(negedge clk); chk("bp_g0", 32'(req_ready), 32'b001);
      step(); req_valid = 3'b010; out_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_tag",   32'(out_tag),   32'd0);
         chk("bp_data",  32'(out_data),  32'd128);
         chk("bp_ready", 32'(req_ready), 32'd0);
         step();
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_regrant", 32'(req_ready), 32'b010);
      chk("bp_drain",   32'(out_valid), 32'd1);
      step(); req_valid = 3'b000;
      @(negedge clk);

`ifdef ACT_UNIT_ARBITER_TANH_EN
      // Tanh results through the shared sigmoid.
      step();
      set_lane(0, 0, 1'b1, 0, 1'b1);
      set_lane(1, 256, 1'b1, 192, 1'b1);
      set_lane(2, 40000, 1'b1, 256, 1'b1);
      req_valid = 3'b100;
      @(negedge clk); chk("tanh_g2", 32'(req_ready), 32'b100);
      step(); req_valid = 3'b001;
      @(negedge clk); chk("tanh_g0", 32'(req_ready), 32'b001);
      step(); req_valid = 3'b010;
      @(negedge clk); chk("tanh_g1", 32'(req_ready), 32'b010);
      step(); set_lane(0, -40000, 1'b1, -256, 1'b1); req_valid = 3'b001;
      @(negedge clk); chk("tanh_g0n", 32'(req_ready), 32'b001);
      step(); req_valid = 3'b000;
      @(negedge clk);
`else
      // Op bit ignored: sigmoid result and out_op low.
      step();
      set_lane(1, 256, 1'b1, 192, 1'b0);
      req_valid = 3'b010;
      @(negedge clk); chk("sig_only_g1", 32'(req_ready), 32'b010);
      step(); req_valid = 3'b000;
      @(negedge clk);
`endif

      // Reset while a result is held: result lost, requester 0 granted first afterwards.
      step();
      set_lane(0, 256, 1'b0, 192, 1'b0);
      req_valid = 3'b001; out_ready = 1'b0;
      @(negedge clk); chk("hr_g0", 32'(req_ready), 32'b001);
      step(); req_valid = 3'b000;
      @(negedge clk); chk("hr_held", 32'(out_valid), 32'd1);
      step(); reset = 1'b1;
      @(negedge clk); chk("hr_rst_ready", 32'(req_ready), 32'd0);
      step();
      reset = 1'b0;
      set_lane(0, 0, 1'b0, 128, 1'b0);
      set_lane(1, 256, 1'b0, 192, 1'b0);
      set_lane(2, -2048, 1'b0, 0, 1'b0);
      req_valid = 3'b111; out_ready = 1'b1;
      @(negedge clk);
      chk("hr_cleared",  32'(out_valid), 32'd0);
      chk("hr_first_g0", 32'(req_ready), 32'b001);
      step(); req_valid = 3'b000;
      @(negedge clk);
      step();
      @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
